// File: rtl/spi_reg_bank.sv
// Decodes SPI command frames from the byte slave into an 8-entry register map and hosts the up/down counter.
// Define SPI_REG_AUTOINC_EN to advance the address after every data byte (burst access).
module spi_reg_bank #(
    parameter int unsigned COUNT_W  = 16,
    parameter logic [7:0]  ID_VALUE = 8'hA5,
    parameter int unsigned PRESC_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_active,
    input  logic               rx_valid,
    input  logic [7:0]         rx_byte,
    output logic [7:0]         tx_byte,
    output logic [4:0]         led,
    output logic [COUNT_W-1:0] count,
    output logic               cmd_err
);

    typedef enum logic [2:0] {IDLE, CMD, WR, RD, ERR} state_e;

`ifdef SPI_REG_AUTOINC_EN
    localparam logic [2:0] ADDR_STEP = 3'd1;
`else
    localparam logic [2:0] ADDR_STEP = 3'd0;
`endif

    state_e               state_q, state_d;
    logic                 fa_q;
    logic [2:0]           addr_q, addr_d;
    logic                 load_q;
    logic [7:0]           tx_q, tx_d;
    logic                 ctrl_en_q, ctrl_en_d, ctrl_dn_q, ctrl_dn_d;
    logic [PRESC_W-1:0]   presc_q, presc_d, psc_q, psc_d;
    logic [4:0]           led_q, led_d;
    logic [7:0]           scratch_q, scratch_d, status_q, status_d, snap_q, snap_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 cmd_err_q;

    logic       rx_ok_s, rise_s, cmd_bad_s, tick_s, clr_s;
    logic       tx_id_s, tx_zero_s, tx_ee_s, cmd_ld_s, wr_en_s, adv_s, rd_req_s, err_s;
    logic [7:0] rd_data_s;

    assign rx_ok_s   = rx_valid & frame_active;
    assign rise_s    = frame_active & ~fa_q;
    assign cmd_bad_s = (rx_byte[6:3] != 4'd0);

    // State register; fa_q resets high so a frame already open at reset release is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fa_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            fa_q    <= frame_active;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!frame_active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise_s) state_d = CMD;
                    else        state_d = IDLE;
                end
                CMD: begin
                    if (rx_valid) begin
                        if (cmd_bad_s)       state_d = ERR;
                        else if (rx_byte[7]) state_d = WR;
                        else                 state_d = RD;
                    end else begin
                        state_d = CMD;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Per-state control strobes
    always_comb begin
        tx_id_s   = 1'b0;
        tx_zero_s = 1'b0;
        tx_ee_s   = 1'b0;
        cmd_ld_s  = 1'b0;
        wr_en_s   = 1'b0;
        adv_s     = 1'b0;
        rd_req_s  = 1'b0;
        err_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_s) tx_id_s = 1'b1;
                else        tx_id_s = 1'b0;
            end
            CMD: begin
                if (rx_ok_s) begin
                    if (cmd_bad_s) begin
                        err_s   = 1'b1;
                        tx_ee_s = 1'b1;
                    end else if (rx_byte[7]) begin
                        cmd_ld_s  = 1'b1;
                        tx_zero_s = 1'b1;
                    end else begin
                        cmd_ld_s = 1'b1;
                        rd_req_s = 1'b1;
                    end
                end else begin
                    err_s = 1'b0;
                end
            end
            WR: begin
                if (rx_ok_s) begin
                    wr_en_s   = 1'b1;
                    adv_s     = 1'b1;
                    tx_zero_s = 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            RD: begin
                if (rx_ok_s) begin
                    adv_s    = 1'b1;
                    rd_req_s = 1'b1;
                end else begin
                    rd_req_s = 1'b0;
                end
            end
            default: err_s = 1'b0;
        endcase
    end

    // Register read mux, addressed by the frame's current address
    always_comb begin
        case (addr_q)
            3'd0:    rd_data_s = {6'd0, ctrl_dn_q, ctrl_en_q};
            3'd1:    rd_data_s = 8'(presc_q);
            3'd2:    rd_data_s = count_q[7:0];
            3'd3:    rd_data_s = snap_q;
            3'd4:    rd_data_s = {3'd0, led_q};
            3'd5:    rd_data_s = scratch_q;
            3'd6:    rd_data_s = status_q;
            3'd7:    rd_data_s = ID_VALUE;
            default: rd_data_s = 8'h00;
        endcase
    end

    // Address, MISO byte and snapshot next state; a read loads one cycle after its byte arrives
    always_comb begin
        if (cmd_ld_s)   addr_d = rx_byte[2:0];
        else if (adv_s) addr_d = addr_q + ADDR_STEP;
        else            addr_d = addr_q;

        if (tx_id_s)        tx_d = ID_VALUE;
        else if (tx_ee_s)   tx_d = 8'hEE;
        else if (tx_zero_s) tx_d = 8'h00;
        else if (load_q)    tx_d = rd_data_s;
        else                tx_d = tx_q;

        if (load_q && (addr_q == 3'd2)) snap_d = count_q[15:8];
        else                            snap_d = snap_q;

        if (err_s && (status_q != 8'hFF)) status_d = status_q + 8'd1;
        else                              status_d = status_q;
    end

    // Writable registers; read-only addresses fall through unchanged
    always_comb begin
        ctrl_en_d = ctrl_en_q;
        ctrl_dn_d = ctrl_dn_q;
        presc_d   = presc_q;
        led_d     = led_q;
        scratch_d = scratch_q;
        if (wr_en_s) begin
            case (addr_q)
                3'd0: begin
                    ctrl_en_d = rx_byte[0];
                    ctrl_dn_d = rx_byte[1];
                end
                3'd1:    presc_d   = rx_byte[PRESC_W-1:0];
                3'd4:    led_d     = rx_byte[4:0];
                3'd5:    scratch_d = rx_byte;
                default: scratch_d = scratch_q;
            endcase
        end else begin
            scratch_d = scratch_q;
        end
    end

    assign clr_s  = wr_en_s & (addr_q == 3'd0) & rx_byte[2];
    assign tick_s = ctrl_en_q & (psc_q == presc_q);

    // Counter and prescaler; a clear write wins over a tick in the same cycle
    always_comb begin
        if (clr_s) begin
            count_d = '0;
            psc_d   = '0;
        end else if (tick_s) begin
            count_d = ctrl_dn_q ? (count_q - COUNT_W'(1)) : (count_q + COUNT_W'(1));
            psc_d   = '0;
        end else if (ctrl_en_q) begin
            count_d = count_q;
            psc_d   = psc_q + PRESC_W'(1);
        end else begin
            count_d = count_q;
            psc_d   = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= 3'd0;
            load_q    <= 1'b0;
            tx_q      <= ID_VALUE;
            ctrl_en_q <= 1'b0;
            ctrl_dn_q <= 1'b0;
            presc_q   <= '0;
            psc_q     <= '0;
            led_q     <= 5'd0;
            scratch_q <= 8'h00;
            status_q  <= 8'h00;
            snap_q    <= 8'h00;
            count_q   <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            load_q    <= rd_req_s;
            tx_q      <= tx_d;
            ctrl_en_q <= ctrl_en_d;
            ctrl_dn_q <= ctrl_dn_d;
            presc_q   <= presc_d;
            psc_q     <= psc_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
            status_q  <= status_d;
            snap_q    <= snap_d;
            count_q   <= count_d;
            cmd_err_q <= err_s;
        end
    end

    assign tx_byte = tx_q;
    assign led     = led_q;
    assign count   = count_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Sits directly downstream of the SPI byte slave. Consumes its received-byte stream (byte strobe plus frame-active level) and decodes command frames into an 8-entry register map.
- Returns the byte the slave shifts out on MISO during the next transfer.
- Hosts the board's free-running up/down counter and LED register, so the Pi can configure and read the counter over SPI.

Parameters:
- COUNT_W, 16, counter width; fixed 16 for the register map (lo/hi bytes).
- ID_VALUE, 8'hA5, constant returned at address 7 and as the first MISO byte of every frame.
- PRESC_W, 8, prescaler counter width; matches the PRESC register.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- frame_active  input  1  chip-select asserted, already synchronised to clk (1 = frame open).
- rx_valid  input  1  one-cycle pulse: rx_byte holds a complete received byte.
- rx_byte  input  8  received MOSI byte.
- tx_byte  output  8  byte the slave loads for the next transfer; registered.
- led  output  5  LED register bits [4:0].
- count  output  COUNT_W  live counter value.
- cmd_err  output  1  one-cycle pulse on a malformed command byte.

Behaviour:
- Reset values: tx_byte=ID_VALUE, led=0, count=0, cmd_err=0, CTRL=0, PRESC=0, SCRATCH=0, STATUS=0, snapshot=0; FSM=IDLE.
- Register map:
  - 0 CTRL rw: bit0 enable, bit1 down, bit2 clear (self-clearing, reads 0), other bits read 0.
  - 1 PRESC rw.
  - 2 CNT_LO ro.
  - 3 CNT_HI ro, returns snapshot.
  - 4 LED rw (bits 7:5 read 0).
  - 5 SCRATCH rw.
  - 6 STATUS ro: saturating error count.
  - 7 ID ro.
  - Writes to ro addresses are ignored.
- FSM states: IDLE, CMD, WR, RD, ERR.
  - IDLE -> CMD on frame_active rising; tx_byte<=ID_VALUE that cycle.
  - CMD on rx_valid: decode rx_byte. bit7=1 write, 0 read; bits[2:0]=addr; bits[6:3] must be 0.
  - Nonzero bits[6:3] -> ERR: cmd_err pulses; STATUS increments, saturating at 255; tx_byte<=8'hEE.
  - Read -> RD: tx_byte<=reg[addr] on the next cycle (latency 1 clk after rx_valid).
  - Write -> WR: tx_byte<=8'h00.
  - WR, each rx_valid: reg[addr]<=rx_byte, addr advances (see Optional Feature), tx_byte<=8'h00.
  - RD, each rx_valid (dummy byte ignored): addr advances, tx_byte<=reg[new addr] one cycle later.
  - ERR: all rx_valid ignored, tx_byte stays 8'hEE.
  - Any state -> IDLE when frame_active low. Mid-frame deassert abandons the frame; completed writes persist.
- rx_valid is honoured only in cycles where frame_active=1. If frame_active falls in the same cycle as rx_valid, the byte is dropped.
- Address increment wraps 7->0 (3-bit).
- CNT_LO read (address 2 loaded into tx_byte) also latches count[15:8] into snapshot. CNT_HI returns snapshot, giving coherent 16-bit reads in one auto-incremented frame.
- Counter prescaler:
  - Counts 0..PRESC; a tick occurs when it equals PRESC, then it reloads 0.
  - PRESC=0 gives a tick every clk.
  - Prescaler is held at 0 while enable=0.
- On tick: count +1 (up) or -1 (down). Wraps FFFF->0000 and 0000->FFFF.
- Precedence within one cycle: clear write > tick. A CTRL write takes effect the following cycle.
- rst asserted mid-frame: immediate return to reset values; frame ignored until the next frame_active rising edge.

Optional Feature:
- Macro SPI_REG_AUTOINC_EN.
  - Defined: addr increments after every data byte in WR/RD (burst access).
  - Undefined: addr stays fixed for the whole frame. Repeated writes overwrite the same register; repeated reads return the same register, with CNT_LO re-latching the snapshot on each read.

Test Plan:
- Frame open, rx 8'h84 then 8'h15, close -> led=5'h15; tx_byte ID_VALUE at frame start then 8'h00.
- Write CTRL=8'h01 with PRESC=3 -> count increments once every 4 clk. Write CTRL=8'h03 -> decrements; from 0 -> 16'hFFFF.
- AUTOINC on, count=16'h12FF: rx 8'h02 then two dummies -> tx_byte 8'hFF, then 8'h12, even if count changes between the two bytes.
- rx 8'h48 (bits 6:3 nonzero) -> cmd_err pulse, tx_byte 8'hEE for the rest of the frame. STATUS reads 1; saturates at 255 after 300 errors.
- rx_valid coincident with frame_active fall -> byte dropped, no register change. rst during a WR burst -> all registers back to reset values.
- AUTOINC off: rx 8'h85, 8'h11, 8'h22 -> SCRATCH=8'h22, LED unchanged. AUTOINC on, write burst from addr 7 -> wraps to addr 0 (CTRL).
